fetch_stage: RTL

//  IF stage of the 16-bit pipelined core: owns the PC, issues reads to the instruction

---
 rtl/fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage - owns the PC, issues instruction-memory reads and writes the IF/ID register.
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   imem_addr/imem_rd         : fetch address and read request, held stable until imem_done
//   imem_data/imem_done       : fetched word and its 1-cycle completion pulse
//   stall_ID                  : ID cannot accept a new instruction this cycle
//   flush/branch_target       : redirect to a new PC (highest non-reset priority)
//   instr/pc2/valid_IF_ID     : IF/ID register contents
//   is_rst                    : IF/ID reset marker for the decoder
//   halted                    : fetch stopped on a HALT instruction
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        stall_ID,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] instr_IF_ID,
    output logic [15:0] pc2_IF_ID,
    output logic        valid_IF_ID,
    output logic        is_rst,
    output logic        halted
);
    typedef enum logic [2:0] {BOOT, ISSUE, WAIT, HOLD, DRAIN, HALTED} state_t;
    state_t state_q, state_d;
    logic [15:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, pc2_q, pc2_d;
    logic [15:0] skid_q, skid_d, skid_pc2_q, skid_pc2_d, pc_inc;
    logic valid_q, valid_d, is_rst_q, fetching, req;
    assign pc_inc    = pc_q + 16'd2;
    assign fetching  = state_q == ISSUE || state_q == WAIT;
    assign req       = fetching || state_q == DRAIN;
    // DRAIN keeps presenting the address of the request the memory cannot abort
    assign imem_addr = state_q == DRAIN ? addr_q : pc_q;
    assign imem_rd   = req;
    assign instr_IF_ID = instr_q;
    assign pc2_IF_ID   = pc2_q;
    assign valid_IF_ID = valid_q;
    assign is_rst      = is_rst_q;
    assign halted      = state_q == HALTED;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        pc2_d      = pc2_q;
        skid_d     = skid_q;
        skid_pc2_d = skid_pc2_q;
        // without a new word, ID consuming the current one leaves a bubble; a stall holds it
        valid_d    = valid_q & stall_ID;
        if (flush) begin
            pc_d    = branch_target & 16'hFFFE;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = (req && !imem_done) ? DRAIN : ISSUE;
            if (fetching) addr_d = pc_q;
        end else begin
            case (state_q)
                BOOT: state_d = ISSUE;
                ISSUE, WAIT: begin
                    if (!imem_done) state_d = WAIT;
                    else begin
                        pc_d = pc_inc;
                        if (stall_ID) begin
                            skid_d     = imem_data;
                            skid_pc2_d = pc_inc;
                            state_d    = HOLD;
                        end else begin
                            instr_d = imem_data;
                            pc2_d   = pc_inc;
                            valid_d = 1'b1;
                            state_d = imem_data[15:11] == HALT_OPC ? HALTED : ISSUE;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_ID) begin
                        instr_d = skid_q;
                        pc2_d   = skid_pc2_q;
                        valid_d = 1'b1;
                        state_d = skid_q[15:11] == HALT_OPC ? HALTED : ISSUE;
                    end
                end
                DRAIN: state_d = imem_done ? ISSUE : DRAIN;
                default: state_d = state_q;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC & 16'hFFFE;
            addr_q     <= 16'h0000;
            instr_q    <= NOP_INSTR;
            pc2_q      <= 16'h0000;
            valid_q    <= 1'b0;
            skid_q     <= NOP_INSTR;
            skid_pc2_q <= 16'h0000;
            is_rst_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            pc2_q      <= pc2_d;
            valid_q    <= valid_d;
            skid_q     <= skid_d;
            skid_pc2_q <= skid_pc2_d;
            is_rst_q   <= 1'b0;
        end
    end
endmodule
